apb_master_bridge: RTL and testbench

Bridges the core's data-memory port (load/store address, write data, read data) onto an APB-style peripheral bus. It sits directly downstream of the datapath's data-memory interface and upstream of RAM/GPO/GPI-style slaves. It decodes the target slave, runs a two-phase SETUP/ACCESS transfer with wait states and a timeout, and returns one registered completion pulse to the core.

---
 rtl/apb_master_bridge.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a single-outstanding core data-memory request into a two-phase
// APB transfer (SETUP then ACCESS). The target slave is decoded from a 64 KB
// peripheral window, with 4 KB per slave. Wait states are bounded by a
// timeout, and the core receives one registered completion pulse with an
// error flag and the read data.
module apb_master_bridge #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  // Core side
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_wdata,
  input  logic [3:0]                 cpu_be,
  output logic [31:0]                cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_err,
  // APB side
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  output logic [3:0]                 PSTRB,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [NUM_SLAVES*32-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  // The wait counter must be able to hold TIMEOUT itself, so it never wraps.
  localparam int                CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [4:0]        NUM_SLAVES_C = 5'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        idx_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_inc;

  logic              addr_hit;
  logic              mapped;
  logic [31:0]       sel_rdata;
  logic              sel_ready;
  logic              go_resp;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  // The upper half selects the peripheral window, and bits [15:12] select
  // the slave. Slave indices beyond NUM_SLAVES count as unmapped.
  assign addr_hit = (cpu_addr[31:16] == BASE_ADDR[31:16]);
  assign mapped   = addr_hit && ({1'b0, cpu_addr[15:12]} < NUM_SLAVES_C);
  assign cnt_inc  = wait_cnt + CNT_W'(1);

  // Route only the selected slave's ready and data; other slaves are ignored.
  always_comb begin
    // NOTE: every combinational output gets a default before the case/loop;
    // a path that leaves one unassigned would infer a latch.
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_rdata = PRDATA[i*32 +: 32];
        sel_ready = PREADY[i];
      end
    end
  end

  // Next-state logic and the response that is captured on entry to RESP.
  always_comb begin
    state_next = state;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (mapped) begin
            state_next = SETUP;
          end else begin
            state_next = RESP;
            resp_err   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        // A ready that coincides with the last allowed wait cycle still
        // completes normally. This is why ready is tested first.
        if (sel_ready) begin
          state_next = RESP;
          resp_rdata = PWRITE ? 32'h0 : sel_rdata;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_next = RESP;
          resp_err   = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RESP is only ever entered from another state, so this is a single pulse.
  assign go_resp = (state_next == RESP);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Wait counter: restarted for each transfer, advances on each
  // not-ready ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_next == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !sel_ready) begin
      wait_cnt <= cnt_inc;
    end
  end

  // Capture the request in IDLE. The bus then stays stable until the next
  // request, whatever the core does to its inputs in the meantime.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these datapath registers are reset as well as the state,
      // because their values are directly visible on the APB outputs.
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      idx_q  <= '0;
    end else if (state == IDLE && cpu_req) begin
      PADDR  <= cpu_addr;
      PWRITE <= cpu_we;
      PWDATA <= cpu_wdata;
      PSTRB  <= cpu_we ? cpu_be : 4'h0;
      idx_q  <= cpu_addr[15:12];
    end
  end

  // Registered completion to the core. rdata persists until the next
  // completion. err is only meaningful alongside ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ready <= go_resp;
      if (go_resp) begin
        cpu_err   <= resp_err;
        cpu_rdata <= resp_rdata;
      end else begin
        cpu_err   <= 1'b0;
      end
    end
  end

  // Bus phase strobes come from the state register only, so reset removes
  // them immediately.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = (state == SETUP || state == ACCESS) && (idx_q == 4'(i));
    end
  end

  assign PENABLE = (state == ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge.
// A behavioural model predicts the latency, error, data and bus-phase counts
// of each transfer from the address decode rules and the slave wait count.
// The bench then compares this prediction with what the DUT actually does.
module tb_apb_master_bridge;

  localparam int NS = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic              PENABLE;
  logic [NS-1:0]     PSEL;
  logic [NS*32-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] lat;        // cycles from the request sample edge to cpu_ready
    logic [31:0] err;
    logic [31:0] rdata;
    logic [31:0] setup_n;    // cycles with PSEL set and PENABLE low
    logic [31:0] access_n;   // cycles with PENABLE high
    logic [31:0] psel_bad;   // cycles with an illegal PSEL/PENABLE combination
    logic [31:0] paddr_bad;  // cycles in which PADDR differed from the request
    logic [31:0] pstrb;
    logic [31:0] pwdata;
    logic [31:0] pwrite;
    logic [31:0] setup_cyc;  // absolute cycle number of the SETUP phase
  } res_t;

  apb_master_bridge #(
    .NUM_SLAVES (NS),
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PENABLE   (PENABLE),
    .PSEL      (PSEL),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the outcome of one transfer follows from the decode
  // rule and the number of not-ready ACCESS cycles the slave inserts.
  function automatic res_t model(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int wait_n, input logic [31:0] data);
    res_t e;
    bit   mapped;
    e = '{default: '0};
    mapped = (addr[31:16] == 16'h1000) && (int'(addr[15:12]) < NS);
    if (!mapped) begin
      e.lat = 1;
      e.err = 1;
    end else begin
      e.setup_n = 1;
      e.pstrb   = we ? {28'h0, be} : 32'h0;
      e.pwdata  = wdata;
      e.pwrite  = {31'h0, we};
      if (wait_n < TO) begin
        e.lat      = 32'(3 + wait_n);
        e.access_n = 32'(wait_n + 1);
        e.rdata    = we ? 32'h0 : data;
      end else begin
        e.lat      = 32'(2 + TO);
        e.access_n = 32'(TO);
        e.err      = 1;
      end
    end
    return e;
  endfunction

  // Drives one request and plays the addressed slave. The slave holds its
  // ready low for wait_n ACCESS cycles. Unselected slaves get random
  // ready/data every cycle. The task returns once the DUT is back in IDLE.
  task automatic run_xfer(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int wait_n, input logic [31:0] data,
                          input bit hold, output res_t r);
    logic [NS-1:0] exp_sel;
    bit            mapped;
    bit            rdy_t;
    int            acc_before;
    r = '{default: '0};
    r.lat = 32'hFFFF_FFFF;
    mapped = (addr[31:16] == 16'h1000) && (int'(addr[15:12]) < NS);
    for (int i = 0; i < NS; i++) exp_sel[i] = mapped && (addr[15:12] == 4'(i));
    acc_before = 0;
    rdy_t = 1'b0;

    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    for (int i = 0; i < NS; i++) begin
      PRDATA[i*32 +: 32] = exp_sel[i] ? data : $urandom;
      PREADY[i]          = exp_sel[i] ? 1'b0 : 1'($urandom);
    end

    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !hold) begin
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_be    = 4'($urandom);
      end
      if (PSEL !== '0 && PSEL !== exp_sel) r.psel_bad++;
      if (PENABLE === 1'b1 && PSEL === '0) r.psel_bad++;
      if (PADDR !== addr) r.paddr_bad++;
      if (PSEL !== '0 && PENABLE === 1'b0) begin
        r.setup_n++;
        if (r.setup_n == 1) begin
          r.setup_cyc = cyc;
          r.pstrb     = {28'h0, PSTRB};
          r.pwdata    = PWDATA;
          r.pwrite    = {31'h0, PWRITE};
        end
      end
      if (PENABLE === 1'b1) begin
        rdy_t = (acc_before >= wait_n);
        acc_before++;
        r.access_n++;
      end
      for (int i = 0; i < NS; i++) begin
        if (exp_sel[i]) begin
          PREADY[i] = rdy_t;
        end else begin
          PREADY[i]          = 1'($urandom);
          PRDATA[i*32 +: 32] = $urandom;
        end
      end
      if (cpu_ready === 1'b1) begin
        r.lat   = 32'(c);
        r.err   = {31'h0, cpu_err};
        r.rdata = cpu_rdata;
        break;
      end
    end

    PREADY = '0;
    @(posedge clk); #1;
    check("ready_single_pulse", {31'h0, cpu_ready}, 32'h0);
  endtask

  task automatic compare(input string t, input res_t r, input res_t e);
    check({t, ".latency"},   r.lat,       e.lat);
    check({t, ".err"},       r.err,       e.err);
    check({t, ".rdata"},     r.rdata,     e.rdata);
    check({t, ".setup_n"},   r.setup_n,   e.setup_n);
    check({t, ".access_n"},  r.access_n,  e.access_n);
    check({t, ".psel_bad"},  r.psel_bad,  32'h0);
    check({t, ".paddr_bad"}, r.paddr_bad, 32'h0);
    check({t, ".pstrb"},     r.pstrb,     e.pstrb);
    check({t, ".pwdata"},    r.pwdata,    e.pwdata);
    check({t, ".pwrite"},    r.pwrite,    e.pwrite);
  endtask

  task automatic do_xfer(input string t, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int wait_n, input logic [31:0] data);
    res_t r;
    run_xfer(we, addr, wdata, be, wait_n, data, 1'b0, r);
    compare(t, r, model(we, addr, wdata, be, wait_n, data));
  endtask

  initial begin
    res_t r1;
    res_t r2;
    int   ready_seen;

    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_be    = '0;
    PRDATA    = '0;
    PREADY    = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.cpu_ready", {31'h0, cpu_ready}, 32'h0);
    check("rst.cpu_err",   {31'h0, cpu_err},   32'h0);
    check("rst.cpu_rdata", cpu_rdata,          32'h0);
    check("rst.psel",      {28'h0, PSEL},      32'h0);
    check("rst.penable",   {31'h0, PENABLE},   32'h0);
    check("rst.paddr",     PADDR,              32'h0);
    check("rst.pwrite",    {31'h0, PWRITE},    32'h0);
    check("rst.pwdata",    PWDATA,             32'h0);
    check("rst.pstrb",     {28'h0, PSTRB},     32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait write to slave 1
    do_xfer("wr0", 1'b1, 32'h1000_1004, 32'hA5A5_0001, 4'hF, 0, 32'h0);

    // Read with three wait states
    do_xfer("rdw3", 1'b0, 32'h1000_0008, 32'h0, 4'h3, 3, 32'hDEAD_BEEF);

    // Unmapped: outside the window, then slave index beyond NUM_SLAVES
    do_xfer("unmap_win", 1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 32'h0);
    do_xfer("unmap_idx", 1'b0, 32'h1000_5000, 32'h0, 4'h0, 0, 32'h0);

    // Timeout with ready never arriving, then ready in the last ACCESS cycle
    do_xfer("tmo",      1'b0, 32'h1000_2010, 32'h0, 4'h0, 1000,   32'h1234_5678);
    do_xfer("tmo_edge", 1'b0, 32'h1000_2014, 32'h0, 4'h0, TO - 1, 32'hCAFE_F00D);

    // Back-to-back: request held high across two transfers
    run_xfer(1'b0, 32'h1000_2000, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b1, r1);
    run_xfer(1'b0, 32'h1000_3004, 32'h0, 4'h0, 0, 32'h3333_3333, 1'b0, r2);
    compare("b2b_1", r1, model(1'b0, 32'h1000_2000, 32'h0, 4'h0, 0, 32'h2222_2222));
    compare("b2b_2", r2, model(1'b0, 32'h1000_3004, 32'h0, 4'h0, 0, 32'h3333_3333));
    check("b2b.interval", r2.setup_cyc - r1.setup_cyc, 32'd4);

    // Reset in the middle of an ACCESS phase
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h1000_1010;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("mid.in_access", {31'h0, PENABLE}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid.psel",    {28'h0, PSEL},    32'h0);
    check("mid.penable", {31'h0, PENABLE}, 32'h0);
    check("mid.paddr",   PADDR,            32'h0);
    ready_seen = 0;
    PREADY = '1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (cpu_ready !== 1'b0) ready_seen++;
    end
    @(negedge clk);
    reset  = 1'b1;
    PREADY = '0;
    @(posedge clk); #1;
    if (cpu_ready !== 1'b0) ready_seen++;
    check("mid.no_ready", ready_seen, 32'h0);
    do_xfer("post_rst", 1'b0, 32'h1000_1010, 32'h0, 4'h0, 1, 32'h0BAD_C0DE);

    // Randomized transfers
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] d;
      logic [3:0]  be;
      logic        we;
      int          w;
      a  = {16'h1000, 4'($urandom_range(0, 5)), 10'($urandom), 2'b00};
      if (k % 7 == 6) a[31:16] = 16'h3000;
      wd = $urandom;
      d  = $urandom;
      be = 4'($urandom);
      we = 1'($urandom);
      w  = (k % 8 == 5) ? TO + 2 : $urandom_range(0, 4);
      do_xfer($sformatf("rnd%0d", k), we, a, wd, be, w, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
